// File: rtl/jk_reg_bank_if.sv
// Control/data bundle for jk_reg_bank: the master drives the update controls,
// and the slave (the register bank) returns its state and status flags.
interface jk_reg_bank_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;
    logic [WIDTH-1:0] chg;

    modport master (
        output en, mode, j, k, d,
        input  q, qbar, tc, chg
    );

    modport slave (
        input  en, mode, j, k, d,
        output q, qbar, tc, chg
    );
endinterface

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK flip-flops with built-in modulo up/down counting,
// parallel load, terminal-count detection and a per-bit change flag.
module jk_reg_bank #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      MAX_COUNT   = 15
) (
    input  logic               clk,
    input  logic               clr,
    jk_reg_bank_if.slave       bus
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] chg_q;
    logic [WIDTH-1:0] chg_d;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        q_next = q_q;
        unique case (bus.mode)
            MODE_JK: begin
                for (int i = 0; i < WIDTH; i++) begin
                    unique case ({bus.j[i], bus.k[i]})
                        2'b00:   q_next[i] = q_q[i];
                        2'b01:   q_next[i] = 1'b0;
                        2'b10:   q_next[i] = 1'b1;
                        default: q_next[i] = ~q_q[i];
                    endcase
                end
            end
            // Out-of-range values (e.g. after a load) snap back into range on the next count.
            MODE_UP: begin
                if (q_q >= MAX_W) begin
                    q_next = '0;
                end else begin
                    q_next = q_q + ONE_W;
                end
            end
            MODE_DOWN: begin
                if (q_q == '0 || q_q > MAX_W) begin
                    q_next = MAX_W;
                end else begin
                    q_next = q_q - ONE_W;
                end
            end
            default: q_next = bus.d;
        endcase
    end

    always_comb begin
        q_d   = q_q;
        chg_d = '0;
        if (bus.en) begin
            q_d   = q_next;
            chg_d = q_q ^ q_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            q_q   <= RESET_VALUE;
            chg_q <= '0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.qbar = ~q_q;
    assign bus.chg  = chg_q;
    assign bus.tc   = bus.en & (((bus.mode == MODE_UP) & (q_q == MAX_W)) |
                                ((bus.mode == MODE_DOWN) & (q_q == '0)));

endmodule
